alt_pfl_pgm_verify_sequencer: RTL
=================================

# alt_pfl_pgm_verify_sequencer

Initiator side of the PFL on-chip verify virtual-JTAG protocol. Drives IR codes and one-cycle virtual-state strobes (UIR/CDR/SDR/UDR) into the on-chip verify responder. Runs a link check (pattern readback), steps through up to 16 flash words with a per-word fetch handshake, then shifts out the 16-bit per-slot verify status and reports pass/fail. Sits between the programming controller and the verify responder, clocked on the same TCK.

## Interface
- PFL_IR_BITS, 5, IR width
- IR_INFO, 'h11, loads link pattern into responder status
- IR_READ_DATA, 'h12, capture/compare instruction
- IR_LOAD_RESET_SHIFT, 'h1C, load shifter, reset status to FFFF, clear slot counter
- IR_INC_COUNTER, 'h1D, advance responder slot counter
- LINK_PATTERN, 16'hA5A5, expected link readback
- ACK_TIMEOUT, 255, max cycles waiting for word_ack (8-bit counter)
- vjtag_tck  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle session request; ignored while busy
- num_words  in  5  words to verify; values >16 clamp to 16; 0 = no words
- word_req  out  1  level; requests next flash word
- word_index  out  4  slot number of requested word
- word_ack  in  1  one-cycle; responder's flash_data_in/ip_flash_data_in valid and held until word_req falls
- vjtag_ir_in  out  PFL_IR_BITS  instruction to responder
- vjtag_virtual_state_uir/cdr/sdr/udr  out  1 each  state strobes
- vjtag_tdi  out  1  shift-in data, constant 0
- vjtag_tdo  in  1  responder shift-out
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- pass  out  1  result, valid from done until next start
- link_err, timeout_err  out  1 each  failure causes, same validity
- status_word  out  16  last shifted-out status/pattern

## Operation
- All outputs registered. Reset: ir_in=0, all strobes 0, word_req=0, word_index=0, busy=0, done=0, pass=0, link_err=0, timeout_err=0, status_word=0, state IDLE. Reset mid-session aborts immediately; no done.
- At most one strobe high per cycle; ir_in changes only in the same cycle as a UIR strobe and holds otherwise.
- States: IDLE -> LINK_INFO (ir=INFO, uir) -> LINK_LOAD (ir=LRS, uir) -> LINK_SHIFT (16 sdr) -> LINK_CHK.
- LINK_CHK: readback != LINK_PATTERN -> status_word=readback, link_err=1, pass=0 -> DONE. Else n=min(num_words,16); n=0 -> RD_LOAD, else WREQ with index 0.
- WREQ: word_req=1, word_index=i; wait word_ack. ACK_TIMEOUT cycles without ack -> timeout_err=1, pass=0, word_req=0 -> DONE.
- After ack: W_IR (ir=READ_DATA, uir) -> W_CDR (cdr) -> W_UDR (udr; word_req drops after this cycle) -> W_INC (ir=INC_COUNTER, uir); i+1<n -> WREQ, else RD_LOAD.
- RD_LOAD (ir=LRS, uir) -> RD_SHIFT (16 sdr) -> DONE: status_word=capture; pass = AND of status_word[n-1:0] (1 when n=0).
- DONE: done=1 one cycle, busy=0 next cycle -> IDLE. Responder is left with status FFFF, counter 0.
- Capture: during sdr cycle k (k=0..15) sample vjtag_tdo as bit k; shift {tdo, cap[15:1]}.
- start coincident with done's cycle ignored; accepted from IDLE only.

## Timing
- busy rises cycle after start; LINK_INFO uir in that same cycle.
- Link phase 19 cycles (1+1+16+1).
- Per word: word_req rises first WREQ cycle; after ack, uir/cdr/udr/uir on 4 consecutive cycles; next word_req rises cycle after W_INC.
- Readout 17 cycles, then done. Zero-latency ack (ack in first WREQ cycle) allowed.
- Total with immediate acks: 19 + 5n + 17 + 1 cycles to done.

## Structure
- Shared package: IR code constants, LINK_PATTERN, state enum.
- One sub-module: alt_pfl_pgm_verify_capture (16-bit TDO capture shifter with clear and shift-enable), reused for link and readout phases.

## Test plan
- Link OK, num_words=4, all words match -> status_word=16'hFFFF, pass=1, done at cycle 19+20+18.
- num_words=16, word 5 mismatch -> status_word=16'hFFDF, pass=0.
- Responder returns 16'hC3C3 on link -> link_err=1, pass=0, status_word=16'hC3C3, no word_req ever.
- word_ack withheld on word 2 -> timeout_err=1 after 255 cycles, word_req=0, done pulses.
- num_words=0 and num_words=20 -> 0: no word_req, pass=1; 20: exactly 16 requests, indices 0..15.
- Reset asserted during RD_SHIFT, then start -> all outputs at reset values, fresh session completes normally; start during busy ignored.

Source files
------------

// File: rtl/alt_pfl_pgm_verify_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the PFL verify sequencer.
package alt_pfl_pgm_verify_sequencer_pkg;

    localparam int unsigned PFL_IR_BITS = 5;
    localparam int unsigned STATUS_W    = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned NW_W        = 5;
    localparam int unsigned BIT_CNT_W   = 4;
    localparam int unsigned ACK_CNT_W   = 8;
    localparam int unsigned ACK_TIMEOUT = 255;
    localparam int unsigned MAX_WORDS   = 16;

    localparam logic [PFL_IR_BITS-1:0] IR_INFO             = PFL_IR_BITS'('h11);
    localparam logic [PFL_IR_BITS-1:0] IR_READ_DATA        = PFL_IR_BITS'('h12);
    localparam logic [PFL_IR_BITS-1:0] IR_LOAD_RESET_SHIFT = PFL_IR_BITS'('h1C);
    localparam logic [PFL_IR_BITS-1:0] IR_INC_COUNTER      = PFL_IR_BITS'('h1D);

    localparam logic [STATUS_W-1:0] LINK_PATTERN = STATUS_W'('hA5A5);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LINK_INFO,
        S_LINK_LOAD,
        S_LINK_SHIFT,
        S_LINK_CHK,
        S_WREQ,
        S_W_IR,
        S_W_CDR,
        S_W_UDR,
        S_W_INC,
        S_RD_LOAD,
        S_RD_SHIFT,
        S_DONE
    } state_e;

    // Mask of the slots that take part in the verdict: bits [n-1:0].
    function automatic logic [STATUS_W-1:0] slot_mask(input logic [NW_W-1:0] n);
        logic [STATUS_W:0] m;
        m = ((STATUS_W+1)'(1) << n) - (STATUS_W+1)'(1);
        return m[STATUS_W-1:0];
    endfunction

    // Limit requested word count to the number of responder slots.
    function automatic logic [NW_W-1:0] clamp_words(input logic [NW_W-1:0] n);
        return (n > NW_W'(MAX_WORDS)) ? NW_W'(MAX_WORDS) : n;
    endfunction

endpackage

// File: rtl/alt_pfl_pgm_verify_capture.sv
// 16-bit TDO capture shifter; LSB-first, first sampled bit ends up in bit 0.
module alt_pfl_pgm_verify_capture
    import alt_pfl_pgm_verify_sequencer_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                shift_i,
    input  logic                tdo_i,
    output logic [STATUS_W-1:0] cap_o,
    output logic [STATUS_W-1:0] cap_nxt_c_o
);

    logic [STATUS_W-1:0] cap_q;

    assign cap_nxt_c_o = {tdo_i, cap_q[STATUS_W-1:1]};
    assign cap_o       = cap_q;

    // Shift in one TDO bit per SDR cycle; clear ahead of each shift phase.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cap_q <= '0;
        end else if (shift_i) begin
            cap_q <= cap_nxt_c_o;
        end
    end

endmodule

// File: rtl/alt_pfl_pgm_verify_sequencer.sv
// Initiator for the PFL on-chip verify virtual-JTAG protocol: link check,
// per-word fetch/compare, status readout and pass/fail report.
module alt_pfl_pgm_verify_sequencer
    import alt_pfl_pgm_verify_sequencer_pkg::*;
(
    input  logic                   vjtag_tck,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NW_W-1:0]        num_words,
    output logic                   word_req,
    output logic [IDX_W-1:0]       word_index,
    input  logic                   word_ack,
    output logic [PFL_IR_BITS-1:0] vjtag_ir_in,
    output logic                   vjtag_virtual_state_uir,
    output logic                   vjtag_virtual_state_cdr,
    output logic                   vjtag_virtual_state_sdr,
    output logic                   vjtag_virtual_state_udr,
    output logic                   vjtag_tdi,
    input  logic                   vjtag_tdo,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   link_err,
    output logic                   timeout_err,
    output logic [STATUS_W-1:0]    status_word
);

    state_e                 state_q;
    logic [PFL_IR_BITS-1:0] ir_q;
    logic                   uir_q, cdr_q, sdr_q, udr_q;
    logic                   word_req_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NW_W-1:0]        n_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [ACK_CNT_W-1:0]   ack_cnt_q;
    logic                   busy_q, done_q, pass_q, link_err_q, timeout_err_q;
    logic [STATUS_W-1:0]    status_q;

    logic [STATUS_W-1:0]    cap;
    logic [STATUS_W-1:0]    cap_nxt_c;
    logic                   cap_clr_c;

    assign cap_clr_c = (state_q == S_LINK_LOAD) || (state_q == S_RD_LOAD);

    alt_pfl_pgm_verify_capture u_capture (
        .clk_i       (vjtag_tck),
        .rst_i       (reset),
        .clr_i       (cap_clr_c),
        .shift_i     (sdr_q),
        .tdo_i       (vjtag_tdo),
        .cap_o       (cap),
        .cap_nxt_c_o (cap_nxt_c)
    );

    // Session FSM; strobes are one-cycle and default low every cycle.
    always_ff @(posedge vjtag_tck) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ir_q          <= '0;
            uir_q         <= 1'b0;
            cdr_q         <= 1'b0;
            sdr_q         <= 1'b0;
            udr_q         <= 1'b0;
            word_req_q    <= 1'b0;
            idx_q         <= '0;
            n_q           <= '0;
            bit_cnt_q     <= '0;
            ack_cnt_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            link_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            status_q      <= '0;
        end else begin
            uir_q  <= 1'b0;
            cdr_q  <= 1'b0;
            sdr_q  <= 1'b0;
            udr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q           <= clamp_words(num_words);
                        pass_q        <= 1'b0;
                        link_err_q    <= 1'b0;
                        timeout_err_q <= 1'b0;
                        busy_q        <= 1'b1;
                        ir_q          <= IR_INFO;
                        uir_q         <= 1'b1;
                        state_q       <= S_LINK_INFO;
                    end
                end
                S_LINK_INFO: begin
                    ir_q    <= IR_LOAD_RESET_SHIFT;
                    uir_q   <= 1'b1;
                    state_q <= S_LINK_LOAD;
                end
                S_LINK_LOAD: begin
                    sdr_q     <= 1'b1;
                    bit_cnt_q <= '0;
                    state_q   <= S_LINK_SHIFT;
                end
                S_LINK_SHIFT: begin
                    if (bit_cnt_q == BIT_CNT_W'(STATUS_W - 1)) begin
                        state_q <= S_LINK_CHK;
                    end else begin
                        sdr_q     <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
                S_LINK_CHK: begin
                    status_q <= cap;
                    if (cap != LINK_PATTERN) begin
                        link_err_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else if (n_q == '0) begin
                        ir_q    <= IR_LOAD_RESET_SHIFT;
                        uir_q   <= 1'b1;
                        state_q <= S_RD_LOAD;
                    end else begin
                        word_req_q <= 1'b1;
                        idx_q      <= '0;
                        ack_cnt_q  <= '0;
                        state_q    <= S_WREQ;
                    end
                end
                S_WREQ: begin
                    if (word_ack) begin
                        ir_q    <= IR_READ_DATA;
                        uir_q   <= 1'b1;
                        state_q <= S_W_IR;
                    end else if (ack_cnt_q == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        word_req_q    <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + ACK_CNT_W'(1);
                    end
                end
                S_W_IR: begin
                    cdr_q   <= 1'b1;
                    state_q <= S_W_CDR;
                end
                S_W_CDR: begin
                    udr_q   <= 1'b1;
                    state_q <= S_W_UDR;
                end
                S_W_UDR: begin
                    word_req_q <= 1'b0;
                    ir_q       <= IR_INC_COUNTER;
                    uir_q      <= 1'b1;
                    state_q    <= S_W_INC;
                end
                S_W_INC: begin
                    if ((NW_W'(idx_q) + NW_W'(1)) < n_q) begin
                        word_req_q <= 1'b1;
                        idx_q      <= idx_q + IDX_W'(1);
                        ack_cnt_q  <= '0;
                        state_q    <= S_WREQ;
                    end else begin
                        ir_q    <= IR_LOAD_RESET_SHIFT;
                        uir_q   <= 1'b1;
                        state_q <= S_RD_LOAD;
                    end
                end
                S_RD_LOAD: begin
                    sdr_q     <= 1'b1;
                    bit_cnt_q <= '0;
                    state_q   <= S_RD_SHIFT;
                end
                S_RD_SHIFT: begin
                    if (bit_cnt_q == BIT_CNT_W'(STATUS_W - 1)) begin
                        status_q <= cap_nxt_c;
                        pass_q   <= &(cap_nxt_c | ~slot_mask(n_q));
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        sdr_q     <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vjtag_ir_in             = ir_q;
    assign vjtag_virtual_state_uir = uir_q;
    assign vjtag_virtual_state_cdr = cdr_q;
    assign vjtag_virtual_state_sdr = sdr_q;
    assign vjtag_virtual_state_udr = udr_q;
    assign vjtag_tdi               = 1'b0;
    assign word_req                = word_req_q;
    assign word_index              = idx_q;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign pass                    = pass_q;
    assign link_err                = link_err_q;
    assign timeout_err             = timeout_err_q;
    assign status_word             = status_q;

endmodule
